// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared constants for the two-master Wishbone arbiter
// Purpose : FSM state codes, grant encodings and watchdog counter width
//           used by wb_arbiter_2m and wb_watchdog.
// Ports   : none (package)
package wb_arb_pkg;

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  // One-hot grant encodings
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Stall counter width
  localparam int WDOG_WIDTH = 16;

  function automatic logic [1:0] state_to_grant(input logic [1:0] st);
    logic [1:0] g;
    case (st)
      ST_OWN0: g = GNT_M0;
      ST_OWN1: g = GNT_M1;
      default: g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// rtl/wb_watchdog.sv - stall watchdog for the Wishbone arbiter
// Purpose : counts consecutive stalled cycles and pulses expire on the
//           TIMEOUT-th one. TIMEOUT = 0 disables the watchdog.
// Ports   : clk    - system clock
//           reset  - asynchronous active-low reset
//           run    - current cycle is stalled (cycle & strobe & !ack)
//           clear  - restart the count (ack, strobe low, owner change)
//           expire - 1-cycle pulse on the TIMEOUT-th stalled cycle
module wb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam logic [WDOG_WIDTH-1:0] LP_LAST =
    (TIMEOUT == 0) ? '0 : WDOG_WIDTH'(TIMEOUT - 1);

  logic [WDOG_WIDTH-1:0] r_count;

  // The count holds the number of stalled cycles already seen, so the
  // cycle that finds LP_LAST in it is the TIMEOUT-th stalled one.
  assign expire = (TIMEOUT != 0) && run && (r_count == LP_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear || expire) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= r_count + WDOG_WIDTH'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - two-master round-robin Wishbone arbiter with bus lock
// Purpose : shares one Wishbone slave between master 0 (GPMC bridge) and
//           master 1 (sequencer). Ownership is locked for a whole cycle;
//           a stall watchdog ends hung transfers with an err pulse.
// Ports   : clk, reset (async active-low)
//           m0_* / m1_* - master address, writedata, write, strobe, cycle in;
//                         readdata, ack, err out
//           s_*         - slave address, writedata, write, strobe, cycle out;
//                         readdata, ack in
//           grant       - one-hot owner (bit0 = m0, bit1 = m1)
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  input  logic                  m0_write,
  input  logic                  m0_strobe,
  input  logic                  m0_cycle,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  input  logic                  m1_write,
  input  logic                  m1_strobe,
  input  logic                  m1_cycle,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [ADDR_WIDTH-1:0] s_address,
  output logic [DATA_WIDTH-1:0] s_writedata,
  output logic                  s_write,
  output logic                  s_strobe,
  output logic                  s_cycle,
  input  logic [DATA_WIDTH-1:0] s_readdata,
  input  logic                  s_ack,
  output logic [1:0]            grant
);

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic       r_last;        // master served most recently
  logic       w_next_last;
  logic       w_own0;
  logic       w_own1;
  logic       w_raw_strobe;
  logic       w_run;
  logic       w_clear;
  logic       w_expire;

  // Next-state: the owner keeps the bus while its cycle stays high; on
  // release the bus goes straight to a waiting master with no idle cycle.
  always_comb begin
    w_next_state = r_state;
    w_next_last  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (m0_cycle && m1_cycle) begin
          w_next_state = r_last ? ST_OWN0 : ST_OWN1;
        end else if (m0_cycle) begin
          w_next_state = ST_OWN0;
        end else if (m1_cycle) begin
          w_next_state = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!m0_cycle) begin
          w_next_last  = 1'b0;
          w_next_state = m1_cycle ? ST_OWN1 : ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (!m1_cycle) begin
          w_next_last  = 1'b1;
          w_next_state = m0_cycle ? ST_OWN0 : ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_last  <= w_next_last;
    end
  end

  assign w_own0 = (r_state == ST_OWN0);
  assign w_own1 = (r_state == ST_OWN1);

  // Slave-side mux; everything reads 0 while idle.
  always_comb begin
    s_address    = '0;
    s_writedata  = '0;
    s_write      = 1'b0;
    s_cycle      = 1'b0;
    w_raw_strobe = 1'b0;
    if (w_own0) begin
      s_address    = m0_address;
      s_writedata  = m0_writedata;
      s_write      = m0_write;
      s_cycle      = m0_cycle;
      w_raw_strobe = m0_strobe;
    end else if (w_own1) begin
      s_address    = m1_address;
      s_writedata  = m1_writedata;
      s_write      = m1_write;
      s_cycle      = m1_cycle;
      w_raw_strobe = m1_strobe;
    end
  end

  // Run uses the un-gated strobe so the expiry cannot feed back on itself;
  // an ack in the expiry cycle drops run, so the ack wins the collision.
  assign w_run   = s_cycle & w_raw_strobe & ~s_ack;
  assign w_clear = ~w_raw_strobe | s_ack | (w_next_state != r_state);

  wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .run   (w_run),
    .clear (w_clear),
    .expire(w_expire)
  );

  assign s_strobe    = w_raw_strobe & ~w_expire;
  assign m0_ack      = s_ack & w_own0;
  assign m1_ack      = s_ack & w_own1;
  assign m0_err      = w_expire & w_own0;
  assign m1_err      = w_expire & w_own1;
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign grant       = state_to_grant(r_state);

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - scoreboard bench for wb_arbiter_2m (TIMEOUT 4 and 0)
module tb_wb_arbiter_2m;

  localparam int AW = 4;
  localparam int DW = 16;

  typedef struct packed {
    logic [1:0]    grant;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          ack0;
    logic          ack1;
    logic          err0;
    logic          err1;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          mc  [2];
  logic          ms  [2];
  logic          mw  [2];
  logic [AW-1:0] ma  [2];
  logic [DW-1:0] mwd [2];
  logic          s_ack;
  logic [DW-1:0] s_rd;

  logic [1:0]    g   [2];
  logic          sc  [2];
  logic          ss  [2];
  logic          sw  [2];
  logic [AW-1:0] sa  [2];
  logic [DW-1:0] swd [2];
  logic          a0  [2];
  logic          a1  [2];
  logic          e0  [2];
  logic          e1  [2];
  logic [DW-1:0] rd0 [2];
  logic [DW-1:0] rd1 [2];

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: owner (-1 = nobody), master served last,
  // consecutive stalled cycles seen by the current transfer.
  int own      [2];
  int last_srv [2];
  int stall    [2];
  int tmo      [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) u_dut (
    .clk(clk), .reset(rst_n),
    .m0_address(ma[0]), .m0_writedata(mwd[0]), .m0_write(mw[0]),
    .m0_strobe(ms[0]), .m0_cycle(mc[0]),
    .m0_readdata(rd0[0]), .m0_ack(a0[0]), .m0_err(e0[0]),
    .m1_address(ma[1]), .m1_writedata(mwd[1]), .m1_write(mw[1]),
    .m1_strobe(ms[1]), .m1_cycle(mc[1]),
    .m1_readdata(rd1[0]), .m1_ack(a1[0]), .m1_err(e1[0]),
    .s_address(sa[0]), .s_writedata(swd[0]), .s_write(sw[0]),
    .s_strobe(ss[0]), .s_cycle(sc[0]),
    .s_readdata(s_rd), .s_ack(s_ack), .grant(g[0])
  );

  wb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)) u_dut_nowd (
    .clk(clk), .reset(rst_n),
    .m0_address(ma[0]), .m0_writedata(mwd[0]), .m0_write(mw[0]),
    .m0_strobe(ms[0]), .m0_cycle(mc[0]),
    .m0_readdata(rd0[1]), .m0_ack(a0[1]), .m0_err(e0[1]),
    .m1_address(ma[1]), .m1_writedata(mwd[1]), .m1_write(mw[1]),
    .m1_strobe(ms[1]), .m1_cycle(mc[1]),
    .m1_readdata(rd1[1]), .m1_ack(a1[1]), .m1_err(e1[1]),
    .s_address(sa[1]), .s_writedata(swd[1]), .s_write(sw[1]),
    .s_strobe(ss[1]), .s_cycle(sc[1]),
    .s_readdata(s_rd), .s_ack(s_ack), .grant(g[1])
  );

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %h, expected %h", name, inst, $time, act, req);
    end
  endtask

  // Expected outputs for the current input set, then advance the model
  // to what ownership and stall history will be after the next edge.
  task automatic model_cycle(input int k, output exp_t e);
    int  o;
    int  nxt;
    bit  stalled;
    bit  expired;
    e = '0;
    e.rd0 = s_rd;
    e.rd1 = s_rd;
    if (!rst_n) begin
      own[k]      = -1;
      last_srv[k] = 1;
      stall[k]    = 0;
    end else begin
      o       = own[k];
      stalled = 1'b0;
      expired = 1'b0;
      if (o >= 0) begin
        e.grant = (o == 0) ? 2'b01 : 2'b10;
        e.cyc   = mc[o];
        e.we    = mw[o];
        e.addr  = ma[o];
        e.wd    = mwd[o];
        stalled = mc[o] && ms[o] && !s_ack;
        expired = stalled && (tmo[k] != 0) && (stall[k] + 1 == tmo[k]);
        e.stb   = ms[o] && !expired;
        if (o == 0) begin
          e.ack0 = s_ack;
          e.err0 = expired;
        end else begin
          e.ack1 = s_ack;
          e.err1 = expired;
        end
      end
      stall[k] = (stalled && !expired) ? stall[k] + 1 : 0;
      if (o < 0) begin
        if (mc[0] && mc[1]) nxt = (last_srv[k] == 0) ? 1 : 0;
        else if (mc[0])     nxt = 0;
        else if (mc[1])     nxt = 1;
        else                nxt = -1;
      end else if (!mc[o]) begin
        last_srv[k] = o;
        nxt = mc[1-o] ? 1 - o : -1;
      end else begin
        nxt = o;
      end
      if (nxt != o) stall[k] = 0;
      own[k] = nxt;
    end
  endtask

  // Push expectations for the inputs now on the pins, then move to the
  // next cycle (inputs are always changed 1 time unit after posedge).
  task automatic issue();
    exp_t e;
    model_cycle(0, e);
    exp_q0.push_back(e);
    model_cycle(1, e);
    exp_q1.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int k, input logic c, input logic s, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    mc[k]  = c;
    ms[k]  = s;
    mw[k]  = w;
    ma[k]  = a;
    mwd[k] = d;
  endtask

  task automatic set_s(input logic ack);
    s_ack = ack;
    s_rd  = DW'($urandom);
  endtask

  task automatic compare(input int k, input exp_t e);
    check("grant",    k, 32'(g[k]), 32'(e.grant));
    check("s_ctrl",   k, 32'({sc[k], ss[k], sw[k]}), 32'({e.cyc, e.stb, e.we}));
    check("s_addr",   k, 32'(sa[k]), 32'(e.addr));
    check("s_wdata",  k, 32'(swd[k]), 32'(e.wd));
    check("acks",     k, 32'({a0[k], a1[k]}), 32'({e.ack0, e.ack1}));
    check("errs",     k, 32'({e0[k], e1[k]}), 32'({e.err0, e.err1}));
    check("readdata", k, {rd0[k], rd1[k]}, {e.rd0, e.rd1});
  endtask

  // Monitor: one popped expectation per instance at every falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        compare(0, e);
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        compare(1, e);
      end
    end
  end

  initial begin
    int mode;
    tmo[0] = 4;
    tmo[1] = 0;
    for (int k = 0; k < 2; k++) begin
      own[k] = -1; last_srv[k] = 1; stall[k] = 0;
      set_m(k, 0, 0, 0, '0, '0);
    end
    rst_n = 1'b0;
    set_s(0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin set_s(0); issue(); end
    rst_n = 1'b1;
    set_s(0); issue();

    // Single master write of 0xA5A5 to address 0, slave acks after 1 cycle.
    set_m(0, 1, 1, 1, 4'h0, 16'hA5A5); set_s(0); issue();
    set_s(0); issue();
    set_s(1); issue();
    set_m(0, 0, 0, 0, '0, '0); set_s(0); issue();
    set_s(0); issue();

    // Tie after reset: m0 first, m1 takes over with no idle cycle.
    set_m(0, 1, 1, 1, 4'h1, 16'h1111); set_m(1, 1, 1, 0, 4'h2, 16'h2222);
    set_s(1); issue();
    set_s(1); issue();
    set_s(1); issue();
    set_m(0, 0, 0, 0, '0, '0); set_s(1); issue();
    set_s(1); issue();
    set_m(1, 0, 0, 0, '0, '0); set_s(0); issue();
    set_s(0); issue();
    // Tie, m0 wins, both drop together, repeat tie goes to m1.
    set_m(0, 1, 1, 0, 4'h3, 16'h3333); set_m(1, 1, 1, 1, 4'h4, 16'h4444);
    set_s(1); issue();
    set_s(1); issue();
    set_m(0, 0, 0, 0, '0, '0); set_m(1, 0, 0, 0, '0, '0); set_s(0); issue();
    set_m(0, 1, 1, 0, 4'h5, 16'h5555); set_m(1, 1, 1, 1, 4'h6, 16'h6666);
    set_s(0); issue();
    set_s(1); issue();

    // Bus lock: m1 owns, three back-to-back strobes while m0 waits.
    for (int i = 0; i < 3; i++) begin
      set_m(1, 1, 1, 1, AW'(i + 8), DW'(16'hB000 + i)); set_s(1); issue();
    end
    set_m(1, 0, 0, 0, '0, '0); set_s(0); issue();
    set_s(1); issue();
    set_m(0, 0, 0, 0, '0, '0); set_s(0); issue();
    set_s(0); issue();

    // Timeout: m0 strobes into a slave that never acks.
    set_m(0, 1, 1, 0, 4'h7, 16'h7777);
    for (int i = 0; i < 11; i++) begin set_s(0); issue(); end
    set_m(0, 0, 0, 0, '0, '0); set_s(0); issue();
    set_s(0); issue();

    // Ack exactly on the expiry cycle.
    set_m(0, 1, 1, 1, 4'hC, 16'hC0DE); set_s(0); issue();
    for (int i = 0; i < 3; i++) begin set_s(0); issue(); end
    set_s(1); issue();
    set_s(0); issue();
    set_m(0, 0, 0, 0, '0, '0); set_s(0); issue();
    set_s(0); issue();

    // Mid-transfer reset while m1 owns with a strobe up.
    set_m(1, 1, 1, 1, 4'hE, 16'hEEEE); set_s(0); issue();
    set_s(0); issue();
    set_s(1);
    rst_n = 1'b0;
    #1;
    check("rst_async_grant", 0, 32'(g[0]), 32'd0);
    check("rst_async_ctrl",  0, 32'({sc[0], ss[0], sw[0]}), 32'd0);
    check("rst_async_bus",   0, 32'({sa[0], swd[0]}), 32'd0);
    check("rst_async_ack",   0, 32'({a0[0], a1[0], e0[0], e1[0]}), 32'd0);
    issue();
    set_m(1, 0, 0, 0, '0, '0); set_s(0); issue();
    rst_n = 1'b1;
    set_m(0, 1, 1, 0, 4'h1, 16'h0101); set_m(1, 1, 1, 0, 4'h2, 16'h0202);
    set_s(0); issue();
    set_s(1); issue();
    set_m(0, 0, 0, 0, '0, '0); set_m(1, 0, 0, 0, '0, '0); set_s(0); issue();
    set_s(0); issue();

    // Randomised traffic with slow-ack and fast-ack phases.
    mode = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) == 0) mode = 1 - mode;
      for (int k = 0; k < 2; k++) begin
        if (mc[k]) begin
          if ($urandom_range(0, 5) == 0) set_m(k, 0, 0, 0, '0, '0);
          else set_m(k, 1, ($urandom_range(0, 3) != 0), 1'($urandom),
                     AW'($urandom), DW'($urandom));
        end else if ($urandom_range(0, 3) == 0) begin
          set_m(k, 1, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
        end
      end
      if (mode == 0) set_s($urandom_range(0, 1) == 1);
      else           set_s($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      issue();
    end
    rst_n = 1'b1;

    @(negedge clk);
    #1;
    check("queue_drain", 0, 32'(exp_q0.size()), 32'd0);
    check("queue_drain", 1, 32'(exp_q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
